// File: rtl/l1_dcache_sa.sv
// l1_dcache_sa: parametrised set-associative, write-back, write-allocate L1 data cache
// with true-LRU replacement, misalignment exceptions and a whole-cache flush.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   cpu_req_*          CPU request: valid/ready handshake, byte addr, write, wdata, wmask
//   cpu_resp_*         one-cycle response: valid, rdata, hit, exception
//   flush_valid/done   whole-cache writeback+invalidate request / one-cycle completion pulse
//   mem_w_*            line write channel: valid/ready, line addr, line data, byte mask
//   mem_r_*            line read channel: valid, line addr; rvalid/rdata complete the read
module l1_dcache_sa #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned CPU_WIDTH  = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
  input  logic                    cpu_req_write,
  input  logic [CPU_WIDTH-1:0]    cpu_req_wdata,
  input  logic [CPU_WIDTH/8-1:0]  cpu_req_wmask,
  output logic                    cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]    cpu_resp_rdata,
  output logic                    cpu_resp_hit,
  output logic                    cpu_resp_exception,
  input  logic                    flush_valid,
  output logic                    flush_done,
  output logic                    mem_w_valid,
  input  logic                    mem_w_ready,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [LINE_WIDTH-1:0]   mem_w_data,
  output logic [LINE_WIDTH/8-1:0] mem_w_wmask,
  output logic                    mem_r_valid,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic                    mem_r_rvalid,
  input  logic [LINE_WIDTH-1:0]   mem_r_rdata
);
  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int unsigned BYTE_W = $clog2(CPU_WIDTH / 8);
  localparam int unsigned WSEL_W = OFF_W - BYTE_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned ENT    = SETS * WAYS;
  localparam int unsigned ENT_W  = $clog2(ENT);
  localparam int unsigned NBYTES = CPU_WIDTH / 8;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLookup    = 3'd1;
  localparam logic [2:0] StWriteback = 3'd2;
  localparam logic [2:0] StRefill    = 3'd3;
  localparam logic [2:0] StRespond   = 3'd4;
  localparam logic [2:0] StFlScan    = 3'd5;
  localparam logic [2:0] StFlWb      = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_write_q;
  logic [CPU_WIDTH-1:0]  req_wdata_q;
  logic [NBYTES-1:0]     req_wmask_q;
  logic [WAY_W-1:0]      victim_q;
  logic [ENT_W-1:0]      fl_q;

  // Entry e = set * WAYS + way, so a linear walk of fl_q is set-major.
  logic [LINE_WIDTH-1:0] data_q [ENT];
  logic [TAG_W-1:0]      tag_q  [ENT];
  logic [WAY_W-1:0]      age_q  [ENT];
  logic [ENT-1:0]        valid_q, dirty_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx, fl_set;
  logic [WSEL_W-1:0] req_wsel;
  logic              misaligned, hit, found, lru_en;
  logic [WAY_W-1:0]  hit_way, vic_way, lru_way;
  int                set_base, hit_ent, vic_ent, fl_ent, lru_ent;

  assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx    = req_addr_q[OFF_W +: IDX_W];
  assign req_wsel   = req_addr_q[BYTE_W +: WSEL_W];
  assign misaligned = |req_addr_q[BYTE_W-1:0];
  assign fl_set     = fl_q[ENT_W-1 -: IDX_W];
  assign set_base   = int'(req_idx) * WAYS;
  assign hit_ent    = set_base + int'(hit_way);
  assign vic_ent    = set_base + int'(victim_q);
  assign fl_ent     = int'(fl_q);
  assign lru_en     = (state_q == StLookup && !misaligned && hit) ||
                      (state_q == StRefill && mem_r_rvalid);
  assign lru_way    = (state_q == StLookup) ? hit_way : victim_q;
  assign lru_ent    = set_base + int'(lru_way);

  function automatic logic [LINE_WIDTH-1:0] merge(input logic [LINE_WIDTH-1:0] line,
                                                  input logic [WSEL_W-1:0] sel,
                                                  input logic [CPU_WIDTH-1:0] wd,
                                                  input logic [NBYTES-1:0] m);
    logic [LINE_WIDTH-1:0] r;
    r = line;
    for (int b = 0; b < NBYTES; b++) begin
      if (m[b]) r[int'(sel) * CPU_WIDTH + b * 8 +: 8] = wd[b * 8 +: 8];
    end
    return r;
  endfunction

  // Tag match and victim choice: lowest invalid way, else the least recently used.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    found   = 1'b0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[set_base + w] && tag_q[set_base + w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found && !valid_q[set_base + w]) begin
        found   = 1'b1;
        vic_way = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_base + w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    cpu_req_ready      = (state_q == StIdle) && !flush_valid;
    cpu_resp_valid     = 1'b0;
    cpu_resp_rdata     = '0;
    cpu_resp_hit       = 1'b0;
    cpu_resp_exception = 1'b0;
    flush_done         = 1'b0;
    mem_w_valid        = 1'b0;
    mem_w_addr         = '0;
    mem_w_data         = '0;
    mem_w_wmask        = '0;
    mem_r_valid        = 1'b0;
    mem_r_addr         = '0;
    unique case (state_q)
      StIdle: begin
        if (flush_valid) state_d = StFlScan;
        else if (cpu_req_valid) state_d = StLookup;
      end
      StLookup: begin
        if (misaligned) begin
          cpu_resp_valid     = 1'b1;
          cpu_resp_exception = 1'b1;
          state_d            = StIdle;
        end else if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_hit   = 1'b1;
          if (!req_write_q) cpu_resp_rdata = data_q[hit_ent][int'(req_wsel) * CPU_WIDTH +: CPU_WIDTH];
          state_d = StIdle;
        end else if (valid_q[set_base + int'(vic_way)] && dirty_q[set_base + int'(vic_way)]) begin
          state_d = StWriteback;
        end else begin
          state_d = StRefill;
        end
      end
      StWriteback: begin
        mem_w_valid = 1'b1;
        mem_w_addr  = {tag_q[vic_ent], req_idx, {OFF_W{1'b0}}};
        mem_w_data  = data_q[vic_ent];
        mem_w_wmask = '1;
        if (mem_w_ready) state_d = StRefill;
      end
      StRefill: begin
        mem_r_valid = 1'b1;
        mem_r_addr  = {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_r_rvalid) state_d = StRespond;
      end
      StRespond: begin
        cpu_resp_valid = 1'b1;
        if (!req_write_q) cpu_resp_rdata = data_q[vic_ent][int'(req_wsel) * CPU_WIDTH +: CPU_WIDTH];
        state_d = StIdle;
      end
      StFlScan: begin
        if (valid_q[fl_ent] && dirty_q[fl_ent]) begin
          state_d = StFlWb;
        end else if (fl_q == ENT_W'(ENT - 1)) begin
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end
      StFlWb: begin
        mem_w_valid = 1'b1;
        mem_w_addr  = {tag_q[fl_ent], fl_set, {OFF_W{1'b0}}};
        mem_w_data  = data_q[fl_ent];
        mem_w_wmask = '1;
        // Dirty is cleared here; the rescan of the same entry then invalidates it.
        if (mem_w_ready) state_d = StFlScan;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      victim_q    <= '0;
      fl_q        <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int e = 0; e < ENT; e++) age_q[e] <= WAY_W'(e % WAYS);
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          fl_q <= '0;
          if (cpu_req_valid && cpu_req_ready) begin
            req_addr_q  <= cpu_req_addr;
            req_write_q <= cpu_req_write;
            req_wdata_q <= cpu_req_wdata;
            req_wmask_q <= cpu_req_wmask;
          end
        end
        StLookup: begin
          if (!misaligned && hit && req_write_q && |req_wmask_q) dirty_q[hit_ent] <= 1'b1;
          if (!misaligned && !hit) victim_q <= vic_way;
        end
        StWriteback: if (mem_w_ready) dirty_q[vic_ent] <= 1'b0;
        StRefill: begin
          if (mem_r_rvalid) begin
            valid_q[vic_ent] <= 1'b1;
            dirty_q[vic_ent] <= req_write_q && |req_wmask_q;
          end
        end
        StFlScan: begin
          if (!(valid_q[fl_ent] && dirty_q[fl_ent])) begin
            valid_q[fl_ent] <= 1'b0;
            dirty_q[fl_ent] <= 1'b0;
            fl_q            <= fl_q + 1'b1;
          end
        end
        StFlWb: if (mem_w_ready) dirty_q[fl_ent] <= 1'b0;
        default: ;
      endcase
      if (lru_en) begin
        for (int v = 0; v < WAYS; v++) begin
          if (age_q[set_base + v] < age_q[lru_ent]) age_q[set_base + v] <= age_q[set_base + v] + 1'b1;
        end
        age_q[lru_ent] <= '0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == StLookup && !misaligned && hit && req_write_q) begin
      data_q[hit_ent] <= merge(data_q[hit_ent], req_wsel, req_wdata_q, req_wmask_q);
    end
    if (state_q == StRefill && mem_r_rvalid) begin
      tag_q[vic_ent]  <= req_tag;
      data_q[vic_ent] <= req_write_q ? merge(mem_r_rdata, req_wsel, req_wdata_q, req_wmask_q)
                                     : mem_r_rdata;
    end
  end
endmodule

// File: doc/l1_dcache_sa.md
Name: l1_dcache_sa

Overview:
- Parametrised set-associative, write-back, write-allocate L1 data cache. Generalises the fixed 8-bit address, 128-bit line, 32-bit word cache bus definitions to configurable ways, sets and widths.
- Adds true-LRU replacement, dirty-line writeback, misalignment exceptions and a whole-cache flush.
- Sits between the pipeline MEM stage (CPU side) and the line-wide memory model (memory side).

Parameters:
- ADDR_WIDTH, 8, byte address width.
- LINE_WIDTH, 128, cache line / memory data width in bits.
- CPU_WIDTH, 32, CPU word width in bits.
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 4, sets per way; power of 2, at least 2.
- Derived: OFF_W = log2(LINE_WIDTH/8), IDX_W = log2(SETS), TAG_W = ADDR_WIDTH - IDX_W - OFF_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  cache can accept a request (IDLE and no flush).
- cpu_req_addr  in  ADDR_WIDTH  byte address.
- cpu_req_write  in  1  1 = store, 0 = load.
- cpu_req_wdata  in  CPU_WIDTH  store data.
- cpu_req_wmask  in  CPU_WIDTH/8  store byte enables.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  CPU_WIDTH  load data; 0 for stores and exceptions.
- cpu_resp_hit  out  1  request hit without memory traffic.
- cpu_resp_exception  out  1  misaligned address.
- flush_valid  in  1  request writeback and invalidation of all lines.
- flush_done  out  1  one-cycle pulse when the flush completes.
- mem_w_valid  out  1  line write request.
- mem_w_ready  in  1  write accepted.
- mem_w_addr  out  ADDR_WIDTH  line-aligned address.
- mem_w_data  out  LINE_WIDTH  line data.
- mem_w_wmask  out  LINE_WIDTH/8  always all ones.
- mem_r_valid  out  1  line read request.
- mem_r_addr  out  ADDR_WIDTH  line-aligned address.
- mem_r_rvalid  in  1  read data valid; completes the read.
- mem_r_rdata  in  LINE_WIDTH  line data.

Behaviour:
- Address split: tag = [ADDR_WIDTH-1 : IDX_W+OFF_W], index = next IDX_W bits, offset = low OFF_W bits. Word select = offset[OFF_W-1 : log2(CPU_WIDTH/8)].
- Reset:
  - All valid and dirty bits cleared; LRU age[way i] = i; FSM goes to IDLE.
  - All outputs 0 except cpu_req_ready = 1 after release.
  - Reset mid-operation drops mem_*_valid immediately. Dirty data is discarded, not written back.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FL_SCAN, FL_WB.
- IDLE:
  - Request accepted when cpu_req_valid && cpu_req_ready; the request is registered and the FSM goes to LOOKUP.
  - flush_valid has priority over a same-cycle request: ready is 0 and the FSM goes to FL_SCAN.
- LOOKUP (cycle T+1 after acceptance):
  - Misaligned access (addr[log2(CPU_WIDTH/8)-1:0] != 0): resp_valid = 1, exception = 1, hit = 0. No state change; back to IDLE.
  - Hit: resp_valid = 1, hit = 1; load returns the selected word. Store merges wdata by wmask; dirty is set if wmask != 0. LRU is updated; back to IDLE.
  - Miss: choose the victim as the lowest-index invalid way, else the way with age WAYS-1. A valid dirty victim goes to WRITEBACK; otherwise the FSM goes to REFILL.
- WRITEBACK:
  - mem_w_valid held with {victim tag, index, 0} address and the victim line until mem_w_ready is sampled high.
  - Then go to REFILL; the victim's dirty bit is cleared.
- REFILL:
  - mem_r_valid held with the line-aligned request address until mem_r_rvalid.
  - Then install the line, set valid, merge store data if the request is a store (dirty if wmask != 0), update LRU, and go to RESPOND.
- RESPOND: resp_valid = 1, hit = 0, rdata = loaded word; then IDLE. Miss latency = writeback wait + refill wait + 2 cycles.
- LRU update on an access to way w: every way with age < age[w] increments; age[w] = 0. Ages remain a permutation of 0..WAYS-1. WAYS = 1 gives a degenerate direct-mapped cache.
- Flush:
  - FL_SCAN walks (set, way) in order, set-major.
  - A valid dirty line goes to FL_WB, which uses the same handshake as WRITEBACK and then returns to the scan.
  - Every line is invalidated and its dirty bit cleared.
  - After the last entry: flush_done pulses for 1 cycle; back to IDLE.
- Only one memory channel is valid at a time. mem_*_valid, address and data are stable while waiting.

Test Plan:
- Read 0x14 after reset -> mem_r_addr = 0x10; reply line with word1 = 0xDEADBEEF -> resp hit = 0, rdata = 0xDEADBEEF. Re-read -> resp at T+1, hit = 1.
- Write 0x14, wdata 0x000000AA, wmask 0001 -> hit = 1. Read 0x14 -> 0xDEADBEAA.
- Read 0x54 (miss, fills way1), read 0x14 (hit), read 0x94 -> evicts the clean 0x54 line: no mem_w, mem_r_addr = 0x90.
- Then read 0x54 -> evicts the dirty 0x10 line: mem_w_addr = 0x10, data word1 = 0xDEADBEAA, wmask all ones, before mem_r_addr = 0x50. Holding mem_w_ready low for 3 cycles keeps mem_w_valid and data stable.
- Read 0x15 -> resp at T+1 with exception = 1, hit = 0, rdata = 0, no memory traffic.
- Flush with exactly one dirty line -> exactly one mem_w, then flush_done pulse; the next read of that line misses.
- Assert rst during REFILL -> mem_r_valid = 0 in the same cycle; after release cpu_req_ready = 1 and the next read of 0x14 misses.
